// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential multiplier.
// Holds the FSM state enumeration and the default operand width.
package mult_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_e;

endpackage

// File: rtl/ripple_carry_adder.sv
// WIDTH-bit ripple-carry adder chained from full-adder cells.
// Ports: x, y, ci in; sum, co out.
module full_adder_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

module ripple_carry_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             ci,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  logic [WIDTH:0] carry;

  assign carry[0] = ci;
  assign co       = carry[WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder_cell u_fa (
      .x  (x[i]),
      .y  (y[i]),
      .ci (carry[i]),
      .s  (sum[i]),
      .co (carry[i+1])
    );
  end

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-add multiplier, one iteration per cycle.
// Ports: clk, rst_n, start, a, b, signed_mode in; busy, done, product out.
module seq_shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mult_state_e        state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic               neg;

  logic [WIDTH-1:0]   add_sum;
  logic               add_co;
  logic [WIDTH:0]     hi_next;
  logic [2*WIDTH-1:0] acc_next;

  // Magnitude of an operand; the most-negative value maps to
  // 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
  function automatic logic [WIDTH-1:0] mag(
    input logic [WIDTH-1:0] v,
    input logic             sm
  );
    return (sm && v[WIDTH-1]) ? -v : v;
  endfunction

  ripple_carry_adder #(
    .WIDTH (WIDTH)
  ) u_add (
    .x   (acc[2*WIDTH-1:WIDTH]),
    .y   (mcand),
    .ci  (1'b0),
    .sum (add_sum),
    .co  (add_co)
  );

  always_comb begin
    hi_next  = mplier[0] ? {add_co, add_sum}
                         : {1'b0, acc[2*WIDTH-1:WIDTH]};
    acc_next = {hi_next, acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand  <= mag(a, signed_mode);
            mplier <= mag(b, signed_mode);
            neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          acc    <= acc_next;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            product <= neg ? -acc_next : acc_next;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench for seq_shift_add_multiplier.
// Drives WIDTH 4, 8 and 16 instances against a plain arithmetic model.
module tb_seq_shift_add_multiplier;

  logic        clk;
  logic        rst_n;
  logic        start_v [3];
  logic [15:0] a_v     [3];
  logic [15:0] b_v     [3];
  logic        sm_v    [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic [7:0]  p4;
  logic [15:0] p8;
  logic [31:0] p16;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_exp [3];

  typedef struct {
    int          idx;
    logic [15:0] a;
    logic [15:0] b;
    logic        sm;
    logic [31:0] exp;
  } vec_t;

  seq_shift_add_multiplier #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]),
    .a(a_v[0][3:0]), .b(b_v[0][3:0]), .signed_mode(sm_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .product(p4)
  );

  seq_shift_add_multiplier #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]),
    .a(a_v[1][7:0]), .b(b_v[1][7:0]), .signed_mode(sm_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .product(p8)
  );

  seq_shift_add_multiplier #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]),
    .a(a_v[2]), .b(b_v[2]), .signed_mode(sm_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .product(p16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wof(int idx);
    return (idx == 0) ? 4 : (idx == 1) ? 8 : 16;
  endfunction

  function automatic logic [31:0] prod(int idx);
    return (idx == 0) ? {24'd0, p4} : (idx == 1) ? {16'd0, p8} : p16;
  endfunction

  function automatic logic [15:0] msk(int w, logic [15:0] v);
    logic [15:0] m;
    m = 16'((32'd1 << w) - 1);
    return v & m;
  endfunction

  // Reference: interpret operands as integers, multiply, keep 2w bits.
  function automatic logic [31:0] ref_mul(
    int w, logic sm, logic [15:0] a, logic [15:0] b
  );
    longint sa;
    longint sb;
    longint p;
    sa = longint'(msk(w, a));
    sb = longint'(msk(w, b));
    if (sm && sa >= (longint'(1) << (w - 1))) sa -= longint'(1) << w;
    if (sm && sb >= (longint'(1) << (w - 1))) sb -= longint'(1) << w;
    p = sa * sb;
    p = p & ((longint'(1) << (2 * w)) - 1);
    return 32'(p);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One operation; returns #1 after the cycle following done.
  task automatic run_op(
    int idx, logic [15:0] a, logic [15:0] b, logic sm,
    logic [31:0] exp, bit hold, bit scramble
  );
    int w;
    w = wof(idx);
    a_v[idx]     = msk(w, a);
    b_v[idx]     = msk(w, b);
    sm_v[idx]    = sm;
    start_v[idx] = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start_v[idx] = 1'b0;
    chk("accept_busy", 32'(busy_v[idx]), 32'd1);
    chk("accept_done", 32'(done_v[idx]), 32'd0);
    for (int j = 1; j <= w; j++) begin
      if (scramble) begin
        a_v[idx]  = msk(w, 16'($urandom));
        b_v[idx]  = msk(w, 16'($urandom));
        sm_v[idx] = ~sm_v[idx];
      end
      @(posedge clk);
      #1;
      if (j < w) begin
        chk("calc_busy", 32'(busy_v[idx]), 32'd1);
        chk("calc_done", 32'(done_v[idx]), 32'd0);
        chk("calc_hold_product", prod(idx), last_exp[idx]);
      end else begin
        chk("done_pulse", 32'(done_v[idx]), 32'd1);
        chk("done_busy", 32'(busy_v[idx]), 32'd0);
        chk("product", prod(idx), exp);
      end
    end
    last_exp[idx] = exp;
    @(posedge clk);
    #1;
    chk("done_clear", 32'(done_v[idx]), 32'd0);
    chk("idle_busy", 32'(busy_v[idx]), 32'd0);
  endtask

  vec_t vecs [8];

  initial begin
    vecs[0] = '{1, 16'd255,  16'd255,  1'b0, 32'h0000FE01};
    vecs[1] = '{1, 16'h0080, 16'h0080, 1'b1, 32'h00004000};
    vecs[2] = '{1, 16'h00FD, 16'h0005, 1'b1, 32'h0000FFF1};
    vecs[3] = '{0, 16'd15,   16'd15,   1'b0, 32'h000000E1};
    vecs[4] = '{0, 16'd0,    16'd9,    1'b0, 32'h00000000};
    vecs[5] = '{1, 16'd0,    16'd0,    1'b1, 32'h00000000};
    vecs[6] = '{0, 16'h8,    16'h7,    1'b1, 32'h000000C8};
    vecs[7] = '{2, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001};

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_v[i]  = 1'b0;
      a_v[i]      = '0;
      b_v[i]      = '0;
      sm_v[i]     = 1'b0;
      last_exp[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_busy", 32'(busy_v[i]), 32'd0);
      chk("reset_done", 32'(done_v[i]), 32'd0);
      chk("reset_product", prod(i), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].sm,
             vecs[i].exp, 1'b0, 1'b0);

    // Start held high, operands toggled during CALC.
    run_op(1, 16'd12, 16'd11, 1'b0, 32'd132, 1'b1, 1'b1);
    start_v[1] = 1'b0;
    @(posedge clk);
    #1;
    chk("held_start_no_rerun", 32'(busy_v[1]), 32'd0);
    chk("held_start_product", prod(1), 32'd132);

    // Reset in the middle of CALC.
    a_v[1] = 16'd100;
    b_v[1] = 16'd100;
    sm_v[1] = 1'b0;
    start_v[1] = 1'b1;
    @(posedge clk);
    #1;
    start_v[1] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", 32'(busy_v[1]), 32'd0);
    chk("midreset_done", 32'(done_v[1]), 32'd0);
    chk("midreset_product", prod(1), 32'd0);
    for (int i = 0; i < 3; i++) last_exp[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 11; j++) begin
      @(posedge clk);
      #1;
      chk("post_reset_no_done", 32'(done_v[1]), 32'd0);
    end
    run_op(1, 16'd7, 16'd9, 1'b0, 32'd63, 1'b0, 1'b0);

    // Random back-to-back regression per width.
    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < 12; n++) begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rs;
        ra = 16'($urandom);
        rb = 16'($urandom);
        rs = 1'($urandom_range(0, 1));
        run_op(i, ra, rb, rs, ref_mul(wof(i), rs, ra, rb), 1'b1, 1'b0);
      end
      start_v[i] = 1'b0;
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_shift_add_multiplier.md
SEQ_SHIFT_ADD_MULTIPLIER -- requirements
Module: seq_shift_add_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal values are 2 to 32.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: operation request, sampled on each rising edge of clk.
REQ-005 SHALL have port a, input, WIDTH bits: multiplicand.
REQ-006 SHALL have port b, input, WIDTH bits: multiplier.
REQ-007 SHALL have port signed_mode, input, 1 bit: 1 = two's-complement operands, 0 = unsigned.
REQ-008 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-010 SHALL have port product, output, 2*WIDTH bits: full, untruncated result.

Function
REQ-011 SHALL implement the FSM states IDLE, CALC and DONE.
REQ-012 SHALL accept start only in IDLE; on acceptance at edge k, it SHALL register a, b and signed_mode, clear the accumulator and iteration counter, and enter CALC.
REQ-013 SHALL ignore start, a, b and signed_mode in CALC and DONE; operands changing after acceptance SHALL have no effect.
REQ-014 SHALL perform one shift-add iteration per cycle in CALC: when the current multiplier LSB is 1, add the multiplicand magnitude to the upper accumulator half through a WIDTH-bit adder with carry-out; then shift the accumulator right by one.
REQ-015 SHALL complete CALC in exactly WIDTH cycles; at edge k+WIDTH it SHALL load product with the final result and enter DONE.
REQ-016 SHALL hold done high for exactly one cycle, from edge k+WIDTH to edge k+WIDTH+1, and then return to IDLE.
REQ-017 SHALL drive busy high exactly while in CALC; busy and done SHALL never be high together.
REQ-018 In signed mode, SHALL multiply operand magnitudes; when the operand signs differ, SHALL two's-complement negate the 2*WIDTH-bit result. The most-negative operand SHALL be handled correctly, since its magnitude fits in WIDTH unsigned bits.
REQ-019 In unsigned mode, SHALL set product to a*b exactly.
REQ-020 SHALL hold product stable from one completion until the next completion; it SHALL not change during CALC.
REQ-021 SHALL accept a start held high continuously in the IDLE cycle after DONE, giving back-to-back operations every WIDTH+2 cycles.
REQ-022 With a zero operand, SHALL still take the full WIDTH cycles and produce product = 0, with no early termination.

Reset
REQ-023 While rst_n is low, SHALL immediately force the FSM to IDLE and set busy = 0, done = 0, product = 0, accumulator = 0 and counter = 0, independent of clk.
REQ-024 SHALL abandon an operation when reset is asserted mid-CALC; no done pulse SHALL follow reset release, and the first start accepted after release SHALL behave as in REQ-012.

Structure
REQ-025 SHALL take the FSM state enumeration and the default WIDTH constant from the shared package mult_pkg.
REQ-026 SHALL instantiate one sub-module, ripple_carry_adder (parameter WIDTH), built from the existing full-adder cells, for the iteration add.
REQ-027 SHALL contain no `*` operator in synthesisable RTL.

Verification
REQ-028 WIDTH=8, unsigned, a=255, b=255, start pulse at edge k -> busy high for 8 cycles, done at edge k+8, product=0xFE01.
REQ-029 WIDTH=8, signed, a=0x80 (-128), b=0x80 -> product=0x4000; a=0xFD (-3), b=0x05 -> product=0xFFF1 (-15).
REQ-030 WIDTH=8, start held high, a and b toggled during CALC -> second start ignored, one done pulse, product equals the first accepted operands' result.
REQ-031 WIDTH=8, rst_n pulsed low at CALC cycle 4 -> outputs zero at once, no done pulse; the next 7*9 operation gives product=63.
REQ-032 WIDTH=4, unsigned, a=15, b=15 -> done after 4 CALC cycles, product=0xE1; a=0, b=9 -> product=0.
REQ-033 Random regression, WIDTH in {4, 8, 16}, both modes, start held high back-to-back -> every product matches the reference model, with done spaced WIDTH+2 cycles apart.
